// File: rtl/key_encoder_pkg.sv
// Shared definitions for the key encoder: FSM state encoding, line/code
// widths, and the one-hot test and priority encoder used on the snapshot.
package key_pkg;

    localparam int NUM_LINES = 4;
    localparam int CODE_W    = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // True when exactly one line is set.
    function automatic logic is_onehot(input logic [NUM_LINES-1:0] v);
        logic [NUM_LINES-1:0] one;
        one = {{(NUM_LINES-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

    // Index of the highest set line; exact for one-hot inputs and doubles
    // as the priority encoder for multi-hot patterns.
    function automatic logic [CODE_W-1:0] encode(input logic [NUM_LINES-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (v[k]) begin
                idx = CODE_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_encoder_input_sync.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
// Each bit is synchronised on its own; no cross-bit coherence is implied.
module input_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0_d, sync_p0_q;
    logic [WIDTH-1:0] sync_p1_d, sync_p1_q;

    // Next values of the two synchroniser stages.
    always_comb begin
        sync_p0_d = d;
        sync_p1_d = sync_p0_q;
    end

    // Synchroniser stages, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0_q <= '0;
            sync_p1_q <= '0;
        end else begin
            sync_p0_q <= sync_p0_d;
            sync_p1_q <= sync_p1_d;
        end
    end

    assign q = sync_p1_q;

endmodule

// File: rtl/key_encoder.sv
// Debounced 4-line to 2-bit key encoder.
// Raw lines are synchronised, a candidate pattern must stay stable for
// DEBOUNCE_CYCLES sampled cycles, then its index is emitted with a
// one-cycle Valid pulse. A release must also be stable for DEBOUNCE_CYCLES
// before a new press is accepted.
// Build option: KEY_ENCODER_PRIORITY_EN -- when defined, stable multi-hot
// patterns are encoded as their highest set line (Valid) instead of being
// rejected with an Error pulse.
module key_encoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [NUM_LINES-1:0] In,
    output logic [CODE_W-1:0]    Out,
    output logic                 Valid,
    output logic                 Error
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_LINES-1:0] sync;

    state_t               state_d, state_q;
    logic [CNT_W-1:0]     cnt_d,   cnt_q;
    logic [NUM_LINES-1:0] snap_d,  snap_q;
    logic [CODE_W-1:0]    out_d,   out_q;
    logic                 valid_d, valid_q;
    logic                 error_d, error_q;

    input_sync #(
        .WIDTH (NUM_LINES)
    ) u_input_sync (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (In),
        .q     (sync)
    );

    // Debounce FSM: next state, counter, snapshot and output pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        out_d   = out_q;
        valid_d = 1'b0;
        error_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sync != '0) begin
                    snap_d  = sync;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (sync == '0) begin
                    state_d = IDLE;
                end else if (sync != snap_q) begin
                    // Pattern moved while still bouncing: restart on it.
                    snap_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
`ifdef KEY_ENCODER_PRIORITY_EN
                    out_d   = encode(snap_q);
                    valid_d = 1'b1;
`else
                    if (is_onehot(snap_q)) begin
                        out_d   = encode(snap_q);
                        valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
`endif
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            HELD: begin
                // Changes among nonzero patterns are ignored until release.
                if (sync == '0) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (sync != '0) begin
                    // Release bounce: back to held without re-emitting.
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign Out   = out_q;
    assign Valid = valid_q;
    assign Error = error_q;

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder with DEBOUNCE_CYCLES = 4: a table of held presses
// with releases, plus hand-written bounce, toggle and async-reset sequences.
module tb_key_encoder;
    import key_pkg::*;

    logic       Clk;
    logic       Rst_n;
    logic [3:0] In;
    logic [1:0] Out;
    logic       Valid;
    logic       Error;

    int n_checks = 0;
    int n_errors = 0;

    key_encoder #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .In    (In),
        .Out   (Out),
        .Valid (Valid),
        .Error (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] in_v;
        int         exp_out;
        int         exp_valid;
        int         exp_error;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive v for n edges; count pulses and record the first pulse edge.
    task automatic run_phase(input logic [3:0] v, input int n,
                             output int vc, output int ec,
                             output int first_ev, output int both);
        vc = 0; ec = 0; first_ev = 0; both = 0;
        In = v;
        for (int i = 1; i <= n; i++) begin
            @(posedge Clk);
            #1;
            if (Valid) vc++;
            if (Error) ec++;
            if (Valid && Error) both++;
            if ((Valid || Error) && first_ev == 0) first_ev = i;
        end
    endtask

    initial begin
        int vc, ec, fe, bo;
        int acc_v, acc_e;
        int bounce_v;

        tbl[0] = '{4'b0100, 2, 1, 0};
        tbl[1] = '{4'b0001, 0, 1, 0};
        tbl[2] = '{4'b0010, 1, 1, 0};
        tbl[3] = '{4'b0100, 2, 1, 0};
        tbl[4] = '{4'b1000, 3, 1, 0};
`ifdef KEY_ENCODER_PRIORITY_EN
        tbl[5] = '{4'b0011, 1, 1, 0};
`else
        tbl[5] = '{4'b0011, 3, 0, 1};
`endif

        // Reset state
        Rst_n = 1'b0;
        In    = 4'b0000;
        #12;
        check("reset_out",   int'(Out),   0);
        check("reset_valid", int'(Valid), 0);
        check("reset_error", int'(Error), 0);
        check("reset_state", int'(dut.state_q), int'(IDLE));
        @(negedge Clk);
        Rst_n = 1'b1;

        // Table: held press, then full release
        for (int t = 0; t < 6; t++) begin
            run_phase(tbl[t].in_v, 12, vc, ec, fe, bo);
            check($sformatf("tbl%0d_valid_cnt", t), vc, tbl[t].exp_valid);
            check($sformatf("tbl%0d_error_cnt", t), ec, tbl[t].exp_error);
            check($sformatf("tbl%0d_pulse_edge", t), fe, 7);
            check($sformatf("tbl%0d_overlap", t), bo, 0);
            check($sformatf("tbl%0d_out_held", t), int'(Out), tbl[t].exp_out);
            run_phase(4'b0000, 10, vc, ec, fe, bo);
            check($sformatf("tbl%0d_rel_valid", t), vc, 0);
            check($sformatf("tbl%0d_rel_error", t), ec, 0);
            check($sformatf("tbl%0d_out_rel", t), int'(Out), tbl[t].exp_out);
            check($sformatf("tbl%0d_rel_idle", t), int'(dut.state_q), int'(IDLE));
        end

        // Toggling 0010/0000 every 2 cycles, then stable 0010
        acc_v = 0; acc_e = 0;
        for (int p = 0; p < 5; p++) begin
            run_phase(4'b0010, 2, vc, ec, fe, bo);
            acc_v += vc; acc_e += ec;
            run_phase(4'b0000, 2, vc, ec, fe, bo);
            acc_v += vc; acc_e += ec;
        end
        check("toggle_no_valid", acc_v, 0);
        check("toggle_no_error", acc_e, 0);
        run_phase(4'b0010, 12, vc, ec, fe, bo);
        check("toggle_stable_valid_cnt", vc, 1);
        check("toggle_stable_edge", fe, 7);
        check("toggle_stable_out", int'(Out), 1);
        run_phase(4'b0000, 10, vc, ec, fe, bo);

        // 1000 held, then release with a bounce
        run_phase(4'b1000, 12, vc, ec, fe, bo);
        check("bounce_press_valid", vc, 1);
        check("bounce_press_out", int'(Out), 3);
        bounce_v = 0;
        for (int k = 1; k <= 12; k++) begin
            In = (k == 3) ? 4'b1000 : 4'b0000;
            @(posedge Clk);
            #1;
            if (Valid || Error) bounce_v++;
            if (k == 3)  check("bounce_e3_release", int'(dut.state_q), int'(RELEASE));
            if (k == 5)  check("bounce_e5_held",    int'(dut.state_q), int'(HELD));
            if (k == 9)  check("bounce_e9_release", int'(dut.state_q), int'(RELEASE));
            if (k == 10) check("bounce_e10_idle",   int'(dut.state_q), int'(IDLE));
        end
        check("bounce_no_pulse", bounce_v, 0);
        check("bounce_out_kept", int'(Out), 3);

        // Async reset mid-debounce with 0001 held
        run_phase(4'b0001, 5, vc, ec, fe, bo);
        check("arst_pre_valid", vc, 0);
        check("arst_pre_state", int'(dut.state_q), int'(DEBOUNCE));
        #3;
        Rst_n = 1'b0;
        #1;
        check("arst_out",   int'(Out),   0);
        check("arst_valid", int'(Valid), 0);
        check("arst_error", int'(Error), 0);
        check("arst_state", int'(dut.state_q), int'(IDLE));
        @(negedge Clk);
        Rst_n = 1'b1;
        run_phase(4'b0001, 12, vc, ec, fe, bo);
        check("arst_after_valid_cnt", vc, 1);
        check("arst_after_edge", fe, 7);
        check("arst_after_out", int'(Out), 0);
        check("arst_after_error", ec, 0);
        run_phase(4'b0000, 10, vc, ec, fe, bo);
        check("arst_release_quiet", vc + ec, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
